// File: rtl/mii_rx_framer_if.sv
// MII receive nibble inputs plus the framed byte stream and end-of-frame report.
// The framer takes the slave view; the PHY side or a bench takes the master view.
interface mii_rx_framer_if;
  logic        mii_rx_dv;
  logic        mii_rx_er;
  logic [3:0]  mii_rxd;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_sof;
  logic        frame_end;
  logic        frame_err;
  logic [15:0] frame_len;

  modport master (
    output mii_rx_dv, mii_rx_er, mii_rxd,
    input  byte_data, byte_valid, byte_sof, frame_end, frame_err, frame_len
  );

  modport slave (
    input  mii_rx_dv, mii_rx_er, mii_rxd,
    output byte_data, byte_valid, byte_sof, frame_end, frame_err, frame_len
  );
endinterface

// File: rtl/mii_rx_framer.sv
// Strips the preamble and SFD from an MII receive stream and packs nibbles into bytes.
// Each frame finishes with one frame_end pulse that carries the byte count and the error status.
module mii_rx_framer #(
  parameter int MIN_PREAMBLE_NIB = 4,
  parameter int MAX_FRAME_BYTES  = 1522
) (
  input  logic           clk,
  input  logic           rst,
  mii_rx_framer_if.slave rx
);
  localparam logic [3:0]  MIN_NIB = 4'(MIN_PREAMBLE_NIB);
  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_nib_q, low_nib_d;
  logic [15:0] len_q, len_d;
  logic        err_q, err_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_valid_q, byte_valid_d;
  logic        byte_sof_q, byte_sof_d;
  logic        frame_end_q, frame_end_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] frame_len_q, frame_len_d;

  logic sfd_ok;
  logic oversize;
  assign sfd_ok   = (rx.mii_rxd == 4'hD) && (pre_cnt_q >= MIN_NIB);
  assign oversize = phase_q && (len_q == MAX_LEN);

  // NOTE: the reset is synchronous and only checked on the clock edge; non-blocking
  // assignments let every register sample the *_d values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      phase_q      <= 1'b0;
      low_nib_q    <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      byte_sof_q   <= 1'b0;
      frame_end_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      phase_q      <= phase_d;
      low_nib_q    <= low_nib_d;
      len_q        <= len_d;
      err_q        <= err_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      byte_sof_q   <= byte_sof_d;
      frame_end_q  <= frame_end_d;
      frame_err_q  <= frame_err_d;
      frame_len_q  <= frame_len_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx.mii_rx_dv) state_d = (rx.mii_rxd == 4'h5) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE:
        if (!rx.mii_rx_dv)              state_d = S_IDLE;
        else if (rx.mii_rx_er)          state_d = S_DROP;
        else if (rx.mii_rxd == 4'h5)    state_d = S_PREAMBLE;
        else if (sfd_ok)                state_d = S_DATA;
        else                            state_d = S_DROP;
      S_DATA:
        if (!rx.mii_rx_dv)              state_d = S_IDLE;
        else if (oversize)              state_d = S_DROP;
      S_DROP:
        if (!rx.mii_rx_dv)              state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d    = pre_cnt_q;
    phase_d      = phase_q;
    low_nib_d    = low_nib_q;
    len_d        = len_q;
    err_d        = err_q;
    byte_data_d  = '0;
    byte_valid_d = 1'b0;
    byte_sof_d   = 1'b0;
    frame_end_d  = 1'b0;
    frame_err_d  = 1'b0;
    frame_len_d  = '0;
    unique case (state_q)
      S_IDLE:
        if (rx.mii_rx_dv && rx.mii_rxd == 4'h5) pre_cnt_d = 4'd1;
      S_PREAMBLE:
        if (rx.mii_rx_dv && !rx.mii_rx_er) begin
          if (rx.mii_rxd == 4'h5 && pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          if (sfd_ok) begin
            phase_d = 1'b0;
            len_d   = '0;
            err_d   = 1'b0;
          end
        end
      S_DATA:
        if (rx.mii_rx_dv) begin
          phase_d = ~phase_q;
          if (rx.mii_rx_er) err_d = 1'b1;
          if (!phase_q) begin
            low_nib_d = rx.mii_rxd;
          end else if (oversize) begin
            // The byte that would exceed the limit is swallowed and the frame is closed as bad.
            frame_end_d = 1'b1;
            frame_err_d = 1'b1;
            frame_len_d = MAX_LEN;
          end else begin
            byte_valid_d = 1'b1;
            byte_data_d  = {rx.mii_rxd, low_nib_q};
            byte_sof_d   = (len_q == '0);
            len_d        = len_q + 16'd1;
          end
        end else begin
          // A leftover low nibble (phase 1) is a dribble nibble: dropped and flagged as an error.
          frame_end_d = 1'b1;
          frame_err_d = err_q | phase_q;
          frame_len_d = len_q;
        end
      default: ;
    endcase
  end

  assign rx.byte_data  = byte_data_q;
  assign rx.byte_valid = byte_valid_q;
  assign rx.byte_sof   = byte_sof_q;
  assign rx.frame_end  = frame_end_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.frame_len  = frame_len_q;
endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: dut_a uses the default size limit, dut_b uses a 16-byte limit.
// Both DUTs receive the same nibble stream.
module tb_mii_rx_framer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  mii_rx_framer_if bus_a ();
  mii_rx_framer_if bus_b ();

  mii_rx_framer dut_a (.clk(clk), .rst(rst), .rx(bus_a));
  mii_rx_framer #(.MIN_PREAMBLE_NIB(4), .MAX_FRAME_BYTES(16)) dut_b (.clk(clk), .rst(rst), .rx(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  int          n_bytes [2];
  int          n_sof   [2];
  int          n_fe    [2];
  int          n_ovl   [2];
  logic [15:0] last_len[2];
  logic        last_err[2];
  logic [7:0]  got_a[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return {4'(15 - i), 4'(i)};
  endfunction

  function automatic void log_out(input int k, input logic bv, input logic sof, input logic [7:0] bd,
                                  input logic fe, input logic ferr, input logic [15:0] flen);
    if (bv) begin
      n_bytes[k]++;
      if (sof) n_sof[k]++;
      if (k == 0) got_a.push_back(bd);
    end
    if (fe) begin
      n_fe[k]++;
      last_len[k] = flen;
      last_err[k] = ferr;
    end
    if (bv && fe) n_ovl[k]++;
  endfunction

  // Drive one nibble, let one edge pass, then record what that edge produced.
  task automatic step(input logic dv, input logic er, input logic [3:0] d);
    bus_a.mii_rx_dv = dv; bus_a.mii_rx_er = er; bus_a.mii_rxd = d;
    bus_b.mii_rx_dv = dv; bus_b.mii_rx_er = er; bus_b.mii_rxd = d;
    @(posedge clk);
    #1;
    log_out(0, bus_a.byte_valid, bus_a.byte_sof, bus_a.byte_data, bus_a.frame_end, bus_a.frame_err, bus_a.frame_len);
    log_out(1, bus_b.byte_valid, bus_b.byte_sof, bus_b.byte_data, bus_b.frame_end, bus_b.frame_err, bus_b.frame_len);
  endtask

  task automatic send_frame(input int npre, input int nbytes, input int er_nib, input bit dribble);
    logic [7:0] b;
    for (int i = 0; i < npre; i++) step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = pat(i);
      step(1'b1, er_nib == 2 * i, b[3:0]);
      step(1'b1, er_nib == 2 * i + 1, b[7:4]);
    end
    if (dribble) step(1'b1, 1'b0, 4'hA);
    step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic check_bytes(input string tag, input int n);
    int bad;
    bad = 0;
    check({tag, "_count"}, 32'(got_a.size()), 32'(n));
    for (int i = 0; i < got_a.size() && i < n; i++)
      if (got_a[i] !== pat(i)) bad++;
    check({tag, "_data"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int fe0, fe1, by0, by1, sof0;
    logic [3:0] std_nib [6];
    logic [7:0] std_byte [3];
    std_nib  = '{4'h0, 4'hF, 4'h1, 4'hE, 4'h2, 4'hD};
    std_byte = '{8'hF0, 8'hE1, 8'hD2};
    for (int k = 0; k < 2; k++) begin
      n_bytes[k] = 0; n_sof[k] = 0; n_fe[k] = 0; n_ovl[k] = 0;
      last_len[k] = '0; last_err[k] = 1'b0;
    end

    // Reset state.
    rst = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h5);
    check("reset_a", 32'({bus_a.byte_data, bus_a.byte_valid, bus_a.byte_sof, bus_a.frame_end,
                          bus_a.frame_err, bus_a.frame_len}), 32'd0);
    check("reset_b", 32'({bus_b.byte_data, bus_b.byte_valid, bus_b.byte_sof, bus_b.frame_end,
                          bus_b.frame_err, bus_b.frame_len}), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 4'h0);

    // Standard frame, checked cycle by cycle.
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, std_nib[2 * i]);
      check("std_gap", 32'(bus_a.byte_valid), 32'd0);
      step(1'b1, 1'b0, std_nib[2 * i + 1]);
      check("std_valid", 32'(bus_a.byte_valid), 32'd1);
      check("std_data", 32'(bus_a.byte_data), 32'(std_byte[i]));
      check("std_sof", 32'(bus_a.byte_sof), (i == 0) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0, 4'h0);
    check("std_fe", 32'(bus_a.frame_end), 32'd1);
    check("std_fe_bv", 32'(bus_a.byte_valid), 32'd0);
    check("std_len", 32'(bus_a.frame_len), 32'd3);
    check("std_err", 32'(bus_a.frame_err), 32'd0);
    step(1'b0, 1'b0, 4'h0);
    check("std_fe_pulse", 32'(bus_a.frame_end), 32'd0);

    // Short preambles are rejected silently; exactly the minimum is accepted.
    fe0 = n_fe[0]; by0 = n_bytes[0];
    step(1'b1, 1'b0, 4'h5); step(1'b1, 1'b0, 4'h5); step(1'b1, 1'b0, 4'hD);
    step(1'b1, 1'b0, 4'h0); step(1'b1, 1'b0, 4'hF); step(1'b1, 1'b0, 4'h1); step(1'b1, 1'b0, 4'hE);
    step(1'b0, 1'b0, 4'h0);
    send_frame(3, 2, -1, 1'b0);
    check("short_fe", 32'(n_fe[0] - fe0), 32'd0);
    check("short_bytes", 32'(n_bytes[0] - by0), 32'd0);
    got_a.delete();
    send_frame(4, 2, -1, 1'b0);
    check("minpre_fe", 32'(n_fe[0] - fe0), 32'd1);
    check("minpre_len", 32'(last_len[0]), 32'd2);
    check("minpre_err", 32'(last_err[0]), 32'd0);
    check_bytes("minpre", 2);

    // rx_er on one data nibble of a 64-byte frame.
    got_a.delete(); fe0 = n_fe[0];
    send_frame(7, 64, 21, 1'b0);
    check_bytes("rxer", 64);
    check("rxer_fe", 32'(n_fe[0] - fe0), 32'd1);
    check("rxer_len", 32'(last_len[0]), 32'd64);
    check("rxer_err", 32'(last_err[0]), 32'd1);

    // Dribble nibble.
    got_a.delete();
    send_frame(7, 10, -1, 1'b1);
    check_bytes("dribble", 10);
    check("dribble_len", 32'(last_len[0]), 32'd10);
    check("dribble_err", 32'(last_err[0]), 32'd1);

    // Oversize on the 16-byte instance; the default instance takes the whole frame.
    fe1 = n_fe[1]; by1 = n_bytes[1];
    send_frame(7, 20, -1, 1'b0);
    step(1'b0, 1'b0, 4'h0);
    check("ovs_bytes", 32'(n_bytes[1] - by1), 32'd16);
    check("ovs_fe", 32'(n_fe[1] - fe1), 32'd1);
    check("ovs_len", 32'(last_len[1]), 32'd16);
    check("ovs_err", 32'(last_err[1]), 32'd1);
    check("ovs_ref_len", 32'(last_len[0]), 32'd20);
    check("ovs_ref_err", 32'(last_err[0]), 32'd0);
    fe1 = n_fe[1]; by1 = n_bytes[1];
    send_frame(7, 16, -1, 1'b0);
    check("max_bytes", 32'(n_bytes[1] - by1), 32'd16);
    check("max_fe", 32'(n_fe[1] - fe1), 32'd1);
    check("max_len", 32'(last_len[1]), 32'd16);
    check("max_err", 32'(last_err[1]), 32'd0);

    // Zero-byte frame.
    fe0 = n_fe[0]; by0 = n_bytes[0];
    send_frame(7, 0, -1, 1'b0);
    check("zero_fe", 32'(n_fe[0] - fe0), 32'd1);
    check("zero_bytes", 32'(n_bytes[0] - by0), 32'd0);
    check("zero_len", 32'(last_len[0]), 32'd0);
    check("zero_err", 32'(last_err[0]), 32'd0);

    // Back-to-back frames separated by one idle cycle.
    fe0 = n_fe[0]; sof0 = n_sof[0];
    send_frame(7, 5, -1, 1'b0);
    check("b2b1_len", 32'(last_len[0]), 32'd5);
    got_a.delete();
    send_frame(7, 6, -1, 1'b0);
    check_bytes("b2b2", 6);
    check("b2b_fe", 32'(n_fe[0] - fe0), 32'd2);
    check("b2b_sof", 32'(n_sof[0] - sof0), 32'd2);
    check("b2b2_len", 32'(last_len[0]), 32'd6);
    check("b2b2_err", 32'(last_err[0]), 32'd0);

    // Reset mid-frame abandons the frame without a frame_end.
    fe0 = n_fe[0]; by0 = n_bytes[0];
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'hD);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'h3);
      step(1'b1, 1'b0, 4'hC);
    end
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h5);
    check("rstmid_a", 32'({bus_a.byte_data, bus_a.byte_valid, bus_a.byte_sof, bus_a.frame_end,
                           bus_a.frame_err, bus_a.frame_len}), 32'd0);
    check("rstmid_b", 32'({bus_b.byte_data, bus_b.byte_valid, bus_b.byte_sof, bus_b.frame_end,
                           bus_b.frame_err, bus_b.frame_len}), 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 4'h3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0);
    check("rstmid_fe", 32'(n_fe[0] - fe0), 32'd0);
    check("rstmid_bytes", 32'(n_bytes[0] - by0), 32'd3);
    got_a.delete();
    send_frame(7, 2, -1, 1'b0);
    check_bytes("after_rst", 2);
    check("after_rst_fe", 32'(n_fe[0] - fe0), 32'd1);
    check("after_rst_len", 32'(last_len[0]), 32'd2);

    check("overlap_a", 32'(n_ovl[0]), 32'd0);
    check("overlap_b", 32'(n_ovl[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
- Upstream stage of the Ethernet receive parser: converts the raw MII receive nibble stream into a byte stream.
- Detects and strips the preamble and SFD (0xD5).
- Assembles nibbles into bytes, low nibble first; the first emitted byte is byte 0 of the destination MAC.
- Reports end of frame with length and error status.
- Feeds the parser's IDLE -> ETH_HEADER transition (byte_sof) and its FCS stage (frame_end).

Parameters:
- MIN_PREAMBLE_NIB, 4, minimum count of 0x5 nibbles that must precede the SFD high nibble 0xD for a frame to be accepted.
- MAX_FRAME_BYTES, 1522, post-SFD byte count above which the frame is aborted as oversize.

Ports:
- clk  input  1  MII receive clock (25 MHz); all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- mii_rx_dv  input  1  MII receive data valid, synchronous to clk.
- mii_rx_er  input  1  MII receive error, synchronous to clk.
- mii_rxd  input  4  MII receive nibble.
- byte_data  output  8  assembled byte, {second nibble, first nibble}.
- byte_valid  output  1  one-cycle strobe; byte_data is valid.
- byte_sof  output  1  high with byte_valid on the first byte after the SFD.
- frame_end  output  1  one-cycle strobe; the frame is finished.
- frame_err  output  1  qualified by frame_end; the frame is bad.
- frame_len  output  16  qualified by frame_end; number of bytes emitted in the frame.

Behaviour:
- Reset: all outputs 0. State IDLE. Nibble phase, counters and error flag cleared. Reset mid-frame abandons the frame silently: no frame_end is produced.
- All outputs are registered.
- A byte is emitted (byte_valid, byte_data) in the cycle after its high nibble is sampled. Latency is 1 cycle from the second nibble.
- States:
  - IDLE: on rx_dv=1 and rxd=0x5, set preamble count to 1 and go to PREAMBLE. On rx_dv=1 with any other rxd, go to DROP.
  - PREAMBLE:
    - rx_dv=0 -> IDLE; no outputs.
    - rxd=0x5 -> increment count, saturating at 15.
    - rxd=0xD and count >= MIN_PREAMBLE_NIB -> DATA; phase=0, length=0, err=0.
    - rxd=0xD with count < MIN_PREAMBLE_NIB, or any other nibble -> DROP.
    - rx_er=1 -> DROP.
  - DATA, rx_dv=1:
    - phase 0: store rxd as the low nibble.
    - phase 1: emit a byte and increment length.
    - Toggle phase each cycle.
    - byte_sof accompanies the first emitted byte only.
    - rx_er=1 sets the sticky err flag; nibbles are still assembled and emitted.
  - DATA, rx_dv=0 (end of frame):
    - In the next cycle, pulse frame_end with frame_len = bytes emitted.
    - frame_err = err | (phase==1). Phase 1 here is a dribble nibble, which is discarded.
    - Go to IDLE.
  - DATA, oversize: if a byte would make length exceed MAX_FRAME_BYTES, that byte is not emitted. Instead, pulse frame_end with frame_err=1 and frame_len=MAX_FRAME_BYTES, then go to DROP.
  - DROP: no outputs. Go to IDLE on rx_dv=0.
- byte_valid and frame_end are never high in the same cycle. The final byte precedes frame_end by at least 1 cycle.
- Zero-byte frames (rx_dv falls right after the SFD) produce frame_end, frame_len=0, frame_err=0. The parser rejects these by length.
- frame_len is 16-bit and cannot wrap, because MAX_FRAME_BYTES < 65536.
- Back-to-back frames: IDLE is re-entered in the cycle after rx_dv=0. A new preamble may start on the very next cycle.
- No backpressure: the downstream stage must accept one byte every 2 cycles.

Test Plan:
- Standard frame: 15×0x5, 0xD, then nibbles 0x0,0xF,0x1,0xE,0x2,0xD; rx_dv drops -> bytes 0xF0(sof),0xE1,0xD2 spaced 2 cycles apart; frame_end 1 cycle after rx_dv low; frame_len=3, frame_err=0.
- Short preamble: 2×0x5, 0xD, data -> no byte_valid and no frame_end; the next valid frame is then received normally.
- rx_er: rx_er=1 on one data nibble of a 64-byte frame -> all 64 bytes emitted; frame_end with frame_err=1, frame_len=64.
- Dribble nibble: 10 bytes plus 1 extra nibble -> 10 bytes emitted; frame_err=1, frame_len=10.
- Oversize: MAX_FRAME_BYTES=16, 20-byte frame -> exactly 16 bytes emitted; frame_end, frame_err=1, frame_len=16; DROP until rx_dv low; no second frame_end.
- Back-to-back frames plus reset: two frames separated by 1 idle cycle -> two correct frame_end pulses; rst asserted mid-frame -> all outputs 0 the next cycle and no frame_end for that frame.
